// File: rtl/wb_spi_slave.sv
// Wishbone-attached SPI mode-0 slave with RX/TX byte FIFOs and a level interrupt.
// Define WB_SPI_SLAVE_LSB_FIRST_EN to add CTRL bit4 (lsb_first shifting).
module wb_spi_slave #(
    parameter int unsigned FIFO_AW = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    output logic        wb_ack_o,
    output logic        intr,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_ss_n,
    output logic        spi_miso,
    output logic        spi_miso_oe
);
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] PtrOne = {{FIFO_AW{1'b0}}, 1'b1};

    typedef enum logic {StIdle, StActive} state_e;

    logic [2:0]       sclk_q, ss_n_q;
    logic [1:0]       mosi_q;
    state_e           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       rx_sh_q, rx_sh_d, tx_sh_q, tx_sh_d;
    logic             load_pend_q, load_pend_d;
    logic [7:0]       rx_mem [Depth];
    logic [7:0]       tx_mem [Depth];
    logic [FIFO_AW:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q;
    logic             rx_ovf_q, rx_ovf_d, tx_udf_q, tx_udf_d;
    logic [4:0]       ctrl_q, ctrl_d;
    logic             ack_q;
    logic [31:0]      dat_q, dat_d;

    logic sclk_rise, sclk_fall, ss_fall, ss_rise, mosi_s, enable, lsb_first;
    logic rx_empty, rx_full, tx_empty, tx_full;
    logic rx_push, rx_push_ok, rx_pop, tx_pop_req, tx_pop, tx_push;
    logic acc, rd, wr;
    logic [1:0] reg_sel;
    logic [7:0] rx_head, tx_head;
    logic unused_ok;

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign ss_fall   = ~ss_n_q[1] & ss_n_q[2];
    assign ss_rise   = ss_n_q[1] & ~ss_n_q[2];
    assign mosi_s    = mosi_q[1];
    assign enable    = ctrl_q[3];
`ifdef WB_SPI_SLAVE_LSB_FIRST_EN
    assign lsb_first = ctrl_q[4];
`else
    assign lsb_first = 1'b0;
`endif

    // Extra pointer bit separates full from empty when the slot indices match.
    assign rx_empty = rx_wptr_q == rx_rptr_q;
    assign tx_empty = tx_wptr_q == tx_rptr_q;
    assign rx_full  = (rx_wptr_q[FIFO_AW] != rx_rptr_q[FIFO_AW]) &&
                      (rx_wptr_q[FIFO_AW-1:0] == rx_rptr_q[FIFO_AW-1:0]);
    assign tx_full  = (tx_wptr_q[FIFO_AW] != tx_rptr_q[FIFO_AW]) &&
                      (tx_wptr_q[FIFO_AW-1:0] == tx_rptr_q[FIFO_AW-1:0]);
    assign rx_head  = rx_mem[rx_rptr_q[FIFO_AW-1:0]];
    assign tx_head  = tx_mem[tx_rptr_q[FIFO_AW-1:0]];

    assign acc     = wb_stb_i & wb_cyc_i & ~ack_q;
    assign rd      = acc & ~wb_we_i;
    assign wr      = acc & wb_we_i & wb_sel_i[0];
    assign reg_sel = wb_adr_i[3:2];

    assign unused_ok = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:8], wb_sel_i[3:1]};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        load_pend_d = load_pend_q;
        rx_push     = 1'b0;
        tx_pop_req  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ss_fall && enable) begin
                    state_d     = StActive;
                    tx_pop_req  = 1'b1;
                    bit_cnt_d   = 3'd0;
                    load_pend_d = 1'b0;
                end
            end
            StActive: begin
                if (ss_rise || !enable) begin
                    state_d     = StIdle;
                    bit_cnt_d   = 3'd0;
                    load_pend_d = 1'b0;
                end else if (sclk_rise) begin
                    rx_sh_d   = lsb_first ? {mosi_s, rx_sh_q[7:1]} : {rx_sh_q[6:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_push     = 1'b1;
                        load_pend_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    if (load_pend_q) begin
                        tx_pop_req  = 1'b1;
                        load_pend_d = 1'b0;
                    end else begin
                        tx_sh_d = lsb_first ? {1'b0, tx_sh_q[7:1]} : {tx_sh_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (tx_pop_req) begin
            tx_sh_d = tx_empty ? 8'hFF : tx_head;
        end
    end

    always_comb begin
        rx_pop     = rd && (reg_sel == 2'd0) && !rx_empty;
        tx_pop     = tx_pop_req && !tx_empty;
        rx_push_ok = rx_push && (!rx_full || rx_pop);
        tx_push    = wr && (reg_sel == 2'd1) && (!tx_full || tx_pop);
        rx_ovf_d   = (rx_ovf_q & ~(wr && (reg_sel == 2'd2) && wb_dat_i[4])) |
                     (rx_push & ~rx_push_ok);
        tx_udf_d   = (tx_udf_q & ~(wr && (reg_sel == 2'd2) && wb_dat_i[5])) |
                     (tx_pop_req & tx_empty);
        ctrl_d     = ctrl_q;
        if (wr && (reg_sel == 2'd3)) begin
`ifdef WB_SPI_SLAVE_LSB_FIRST_EN
            ctrl_d = wb_dat_i[4:0];
`else
            ctrl_d = {1'b0, wb_dat_i[3:0]};
`endif
        end
        dat_d = 32'h0;
        if (rd) begin
            unique case (reg_sel)
                2'd0: dat_d = rx_empty ? 32'h0 : {24'h0, rx_head};
                2'd1: dat_d = 32'h0;
                2'd2: dat_d = {26'h0, tx_udf_q, rx_ovf_q, state_q == StActive,
                               tx_empty, tx_full, !rx_empty};
                2'd3: dat_d = {27'h0, ctrl_q};
                default: dat_d = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q      <= 3'b000;
            ss_n_q      <= 3'b111;
            mosi_q      <= 2'b00;
            state_q     <= StIdle;
            bit_cnt_q   <= 3'd0;
            rx_sh_q     <= 8'h00;
            tx_sh_q     <= 8'hFF;
            load_pend_q <= 1'b0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            rx_ovf_q    <= 1'b0;
            tx_udf_q    <= 1'b0;
            ctrl_q      <= 5'h0;
            ack_q       <= 1'b0;
            dat_q       <= 32'h0;
        end else begin
            sclk_q      <= {sclk_q[1:0], spi_sclk};
            ss_n_q      <= {ss_n_q[1:0], spi_ss_n};
            mosi_q      <= {mosi_q[0], spi_mosi};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            load_pend_q <= load_pend_d;
            if (rx_push_ok) rx_wptr_q <= rx_wptr_q + PtrOne;
            if (rx_pop)     rx_rptr_q <= rx_rptr_q + PtrOne;
            if (tx_push)    tx_wptr_q <= tx_wptr_q + PtrOne;
            if (tx_pop)     tx_rptr_q <= tx_rptr_q + PtrOne;
            rx_ovf_q    <= rx_ovf_d;
            tx_udf_q    <= tx_udf_d;
            ctrl_q      <= ctrl_d;
            ack_q       <= acc;
            dat_q       <= dat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_push_ok) rx_mem[rx_wptr_q[FIFO_AW-1:0]] <= rx_sh_d;
        if (tx_push)    tx_mem[tx_wptr_q[FIFO_AW-1:0]] <= wb_dat_i[7:0];
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign intr        = (ctrl_q[0] & !rx_empty) | (ctrl_q[1] & tx_empty) |
                         (ctrl_q[2] & (rx_ovf_q | tx_udf_q));
    assign spi_miso    = lsb_first ? tx_sh_q[0] : tx_sh_q[7];
    assign spi_miso_oe = state_q == StActive;

endmodule

// File: tb/tb_wb_spi_slave.sv
// Bench for wb_spi_slave: register vector table, directed SPI frames and randomized
// rounds checked against a queue-based model of the FIFOs and sticky flags.
module tb_wb_spi_slave;
    localparam int Depth = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] wb_adr_i = '0, wb_dat_i = '0, wb_dat_o;
    logic        wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;
    logic [3:0]  wb_sel_i = 4'h0;
    logic        intr, spi_miso, spi_miso_oe;
    logic        spi_sclk = 1'b0, spi_mosi = 1'b0, spi_ss_n = 1'b1;

    wb_spi_slave #(.FIFO_AW(2)) dut (
        .clk(clk), .reset(reset), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_we_i(wb_we_i),
        .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .intr(intr), .spi_sclk(spi_sclk),
        .spi_mosi(spi_mosi), .spi_ss_n(spi_ss_n), .spi_miso(spi_miso),
        .spi_miso_oe(spi_miso_oe)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       m_ovf = 1'b0, m_udf = 1'b0;
    logic [3:0] m_ctrl = 4'h0;

    logic [7:0] m_out[$];
    logic [7:0] m_in[$];
    logic [7:0] exp_miso[$];

    typedef struct {
        logic [3:0]  adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        chk;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb_xfer(input logic [3:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, output logic [31:0] rdat);
        @(posedge clk); #1;
        wb_adr_i = {28'h0, adr}; wb_we_i = we; wb_sel_i = sel; wb_dat_i = wdat;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge clk); #1;
        chk("ack_rise", {31'h0, wb_ack_o}, 32'h1);
        rdat = wb_dat_o;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        chk("ack_fall", {31'h0, wb_ack_o}, 32'h0);
    endtask

    task automatic reg_write(input logic [3:0] adr, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(adr, 1'b1, 4'hF, d, dummy);
        case (adr)
            4'h4: if (txq.size() < Depth) txq.push_back(d[7:0]);
            4'h8: begin
                if (d[4]) m_ovf = 1'b0;
                if (d[5]) m_udf = 1'b0;
            end
            4'hC: m_ctrl = d[3:0];
            default: ;
        endcase
    endtask

    function automatic logic [31:0] status_exp();
        return {26'h0, m_udf, m_ovf, 1'b0, txq.size() == 0, txq.size() == Depth,
                rxq.size() != 0};
    endfunction

    function automatic logic intr_exp();
        return (m_ctrl[0] & (rxq.size() != 0)) | (m_ctrl[1] & (txq.size() == 0)) |
               (m_ctrl[2] & (m_ovf | m_udf));
    endfunction

    task automatic check_status(input string name);
        logic [31:0] r;
        wb_xfer(4'h8, 1'b0, 4'hF, 32'h0, r);
        chk({name, "_status"}, r, status_exp());
        chk({name, "_intr"}, {31'h0, intr}, {31'h0, intr_exp()});
    endtask

    task automatic rx_read(input string name);
        logic [31:0] r, e;
        e = (rxq.size() != 0) ? {24'h0, rxq.pop_front()} : 32'h0;
        wb_xfer(4'h0, 1'b0, 4'hF, 32'h0, r);
        chk(name, r, e);
    endtask

    function automatic logic [7:0] m_tx_pop();
        if (txq.size() != 0) return txq.pop_front();
        m_udf = 1'b1;
        return 8'hFF;
    endfunction

    function automatic void m_rx_push(input logic [7:0] b);
        if (rxq.size() < Depth) rxq.push_back(b);
        else m_ovf = 1'b1;
    endfunction

    // Mode-0 master at clk/16; MISO sampled just before each rising edge.
    task automatic spi_frame(input int nbits);
        logic [7:0] txb, rxb;
        txb = 8'h00; rxb = 8'h00;
        m_in.delete();
        spi_ss_n = 1'b0;
        repeat (8) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i % 8 == 0) txb = m_out[i / 8];
            spi_mosi = txb[7];
            txb = {txb[6:0], 1'b0};
            repeat (8) @(posedge clk);
            rxb = {rxb[6:0], spi_miso};
            spi_sclk = 1'b1;
            repeat (8) @(posedge clk);
            spi_sclk = 1'b0;
            if (i % 8 == 7) m_in.push_back(rxb);
        end
        repeat (8) @(posedge clk);
        spi_ss_n = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    // Load at frame start, after each byte on the next falling edge; the last load is lost.
    task automatic do_frame(input int n, input string name);
        logic [7:0] nxt;
        exp_miso.delete();
        exp_miso.push_back(m_tx_pop());
        for (int b = 0; b < n; b++) begin
            m_rx_push(m_out[b]);
            nxt = m_tx_pop();
            if (b < n - 1) exp_miso.push_back(nxt);
        end
        spi_frame(n * 8);
        chk({name, "_nbytes"}, m_in.size(), n);
        for (int b = 0; b < n && b < m_in.size(); b++)
            chk($sformatf("%s_miso%0d", name, b), {24'h0, m_in[b]}, {24'h0, exp_miso[b]});
    endtask

    function automatic void add_vec(input logic [3:0] a, input logic we, input logic [3:0] s,
                                    input logic [31:0] w, input logic c, input logic [31:0] e);
        vec_t v;
        v.adr = a; v.we = we; v.sel = s; v.wdat = w; v.chk = c; v.exp = e;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] ctrl_rb;
        int k, n;

`ifdef WB_SPI_SLAVE_LSB_FIRST_EN
        ctrl_rb = 32'h1F;
`else
        ctrl_rb = 32'h0F;
`endif
        add_vec(4'h8, 0, 4'hF, 0, 1, 32'h04);
        add_vec(4'hC, 0, 4'hF, 0, 1, 32'h00);
        add_vec(4'hC, 1, 4'hF, 32'h1F, 0, 0);
        add_vec(4'hC, 0, 4'hF, 0, 1, ctrl_rb);
        add_vec(4'hC, 1, 4'hF, 32'h00, 0, 0);
        add_vec(4'h0, 0, 4'hF, 0, 1, 32'h00);
        add_vec(4'h4, 1, 4'hF, 32'h11, 0, 0);
        add_vec(4'h8, 0, 4'hF, 0, 1, 32'h00);
        add_vec(4'h4, 1, 4'hF, 32'h22, 0, 0);
        add_vec(4'h4, 1, 4'hF, 32'h33, 0, 0);
        add_vec(4'h4, 1, 4'hF, 32'h44, 0, 0);
        add_vec(4'h8, 0, 4'hF, 0, 1, 32'h02);
        add_vec(4'h4, 1, 4'hF, 32'h55, 0, 0);
        add_vec(4'hC, 1, 4'h0, 32'h08, 0, 0);
        add_vec(4'hC, 0, 4'hF, 0, 1, 32'h00);
        add_vec(4'h8, 0, 4'hF, 0, 1, 32'h02);

        repeat (4) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("rst_miso", {31'h0, spi_miso}, 32'h1);
        chk("rst_oe", {31'h0, spi_miso_oe}, 32'h0);
        chk("rst_intr", {31'h0, intr}, 32'h0);
        chk("rst_ack", {31'h0, wb_ack_o}, 32'h0);
        chk("rst_dat", wb_dat_o, 32'h0);

        foreach (vecs[i]) begin
            wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].sel, vecs[i].wdat, r);
            if (vecs[i].chk) chk($sformatf("vec%0d", i), r, vecs[i].exp);
        end
        txq = '{8'h11, 8'h22, 8'h33, 8'h44};

        // FIFO contents drained by a 3-byte frame, last loaded byte lost
        reg_write(4'hC, 32'h08);
        m_out = '{8'h5A, 8'hC3, 8'h0F};
        do_frame(3, "pre");
        for (int i = 0; i < 4; i++) rx_read($sformatf("pre_rx%0d", i));
        check_status("pre");
        reg_write(4'h8, 32'h30);

        // Basic exchange
        reg_write(4'h4, 32'hA5);
        m_out = '{8'h3C};
        do_frame(1, "basic");
        rx_read("basic_rx");
        rx_read("basic_rx_empty");
        check_status("basic");
        reg_write(4'h8, 32'h30);

        // Underflow
        m_out = '{8'h12, 8'h34};
        do_frame(2, "udf");
        check_status("udf_set");
        reg_write(4'h8, 32'h20);
        check_status("udf_clr");
        rx_read("udf_rx0");
        rx_read("udf_rx1");
        reg_write(4'h8, 32'h30);

        // Overflow with error interrupt
        m_out = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        do_frame(5, "ovf");
        reg_write(4'hC, 32'h0C);
        chk("ovf_intr", {31'h0, intr}, 32'h1);
        check_status("ovf");
        for (int i = 0; i < 5; i++) rx_read($sformatf("ovf_rx%0d", i));
        reg_write(4'h8, 32'h30);
        check_status("ovf_clr");

        // Aborted frame after 4 bits, then a clean one
        m_out = '{8'hF0};
        void'(m_tx_pop());
        spi_frame(4);
        check_status("abort");
        m_out = '{8'h81};
        do_frame(1, "after_abort");
        rx_read("after_abort_rx");
        reg_write(4'h8, 32'h30);

        // Randomized rounds
        for (int rnd = 0; rnd < 6; rnd++) begin
            reg_write(4'hC, {28'h0, 1'b1, 3'($urandom_range(0, 7))});
            k = $urandom_range(0, 5);
            for (int i = 0; i < k; i++) reg_write(4'h4, {24'h0, 8'($urandom)});
            check_status($sformatf("r%0d_pre", rnd));
            n = $urandom_range(1, 5);
            m_out.delete();
            for (int i = 0; i < n; i++) m_out.push_back(8'($urandom));
            do_frame(n, $sformatf("r%0d", rnd));
            check_status($sformatf("r%0d_post", rnd));
            k = $urandom_range(0, 5);
            for (int i = 0; i < k; i++) rx_read($sformatf("r%0d_rx%0d", rnd, i));
            reg_write(4'h8, {26'h0, 2'($urandom), 4'h0});
            check_status($sformatf("r%0d_clr", rnd));
        end
        while (rxq.size() != 0) rx_read("drain");

        // Asynchronous reset in the middle of a frame
        reg_write(4'hC, 32'h0A);
        m_out = '{8'h99};
        do_frame(1, "prerst");
        chk("prerst_intr", {31'h0, intr}, 32'h1);
        spi_ss_n = 1'b0;
        repeat (8) @(posedge clk);
        spi_sclk = 1'b1; repeat (8) @(posedge clk);
        spi_sclk = 1'b0; repeat (8) @(posedge clk);
        chk("prerst_oe", {31'h0, spi_miso_oe}, 32'h1);
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("arst_miso", {31'h0, spi_miso}, 32'h1);
        chk("arst_oe", {31'h0, spi_miso_oe}, 32'h0);
        chk("arst_intr", {31'h0, intr}, 32'h0);
        chk("arst_ack", {31'h0, wb_ack_o}, 32'h0);
        chk("arst_dat", wb_dat_o, 32'h0);
        spi_ss_n = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        txq.delete(); rxq.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_ctrl = 4'h0;
        check_status("postrst");
        rx_read("postrst_rx");
        wb_xfer(4'hC, 1'b0, 4'hF, 32'h0, r);
        chk("postrst_ctrl", r, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
